tag_tx_ctrl_anc: RTL
====================

// Module: tag_tx_ctrl_anc
// PURPOSE
//  Anchor-side transmit sequencer; drives the tag-chip RX controller's protocol.
//  Per hop: raises SYNC/SCAN GPIO trigger, emits +AMP loc-sync tone, then -AMP hop-sync tone.
//  Then passes upstream hop IQ through with tx_valid. Sits between hop generator and radio TX IQ.
// PARAMETERS
//  DATA_WIDTH      16     IQ sample width, two's complement
//  GPIO_REG_WIDTH  12     front-panel GPIO width
//  SYNC_SIG_N      8192   loc-sync length (cycles); 3*SYNC_SIG_N must be <= 65536
//  SYNC_AMP        32000  sync tone amplitude; I = +AMP (LOC) / -AMP (HOP_SYNC), Q = 0
//  TRIG_LEN        40     cycles GPIO sync trigger held high (>= 4 * peer GPIO clk div)
//  GAP_N           1024   idle cycles between hops
//  NUM_HOPS        64     hops per burst; hop_idx width = $clog2(NUM_HOPS)
//  ACK_TIMEOUT     4096   ack wait limit (ack feature only)
// PORTS
//  clk           in   1     clock
//  reset_n       in   1     async active-low reset
//  start         in   1     1-cycle pulse, begins burst; ignored while busy
//  abort         in   1     forces IDLE next cycle
//  scan_en       in   1     sampled at start; selects short HOP_SYNC (scan mode)
//  itx_in/qtx_in in   DW    upstream hop IQ
//  fp_gpio_in    in   GW    GPIO pins in
//  fp_gpio_out   out  GW    GPIO pins out
//  fp_gpio_ddr   out  GW    constant 12'h044 (SYNC 0x004, SCAN 0x040 outputs)
//  itx_out/qtx_out out DW   TX IQ
//  tx_valid      out  1     high while hop IQ is passed through
//  tx_state      out  3     current state encoding
//  hop_idx       out  HW    current hop number
//  busy          out  1     state != IDLE
//  done          out  1     1-cycle pulse after last hop's GAP
//  ack_err       out  1     sticky ack-timeout flag (0 when feature absent)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, all outputs 0 except fp_gpio_ddr; counters 0; scan latch 0.
//  States: IDLE=0, TRIG=1, LOC=2, HSYNC=3, HTX=4, GAP=5, ACKW=6. One 16-bit down-counter.
//  Counter reload: to L-1 on state entry; leave state when counter==0. State lasts L cycles.
//  IDLE: start & !abort -> TRIG; latch scan_en; hop_idx=0.
//  TRIG: L=TRIG_LEN; gpio_out[2]=1; gpio_out[6]=scan latch; IQ=0.
//  LOC: L=SYNC_SIG_N; I=+AMP; SCAN bit still held; SYNC bit low.
//  HSYNC: L=SYNC_SIG_N if scan latch, else 3*SYNC_SIG_N; I=-AMP.
//  HTX: L=2*SYNC_SIG_N+1; out=in (registered, 1-cycle latency); tx_valid=1.
//  GAP: L=GAP_N; IQ=0. Exit: if hop_idx==NUM_HOPS-1, go IDLE and pulse done.
//  GAP exit otherwise: hop_idx+1, go TRIG.
//  IQ/GPIO outputs are registered from next-state: first +AMP sample appears on the cycle LOC is entered.
//  abort in any state: IDLE next cycle, outputs/tx_valid/GPIO cleared, no done; abort beats start.
//  hop_idx never wraps; holds last value in IDLE until next start.
//  -SYNC_AMP formed in DATA_WIDTH two's complement; no saturation (SYNC_AMP < 2^(DW-1)).
//  fp_gpio_in passes through a 2-flop synchronizer before use.
// CONFIGURATION
//  TAG_TX_ACK_CHECK_EN defined:
//    - after TRIG, enter ACKW; wait for synced fp_gpio_in bit 0 (peer sync_ready) high.
//    - bit 0 seen within ACK_TIMEOUT cycles -> LOC (counter reloaded).
//    - else set ack_err (sticky until reset or next start) and go IDLE, no done.
//  Not defined: ACKW unreachable, TRIG -> LOC directly, fp_gpio_in unused, ack_err tied 0.
// TESTING (SYNC_SIG_N=16, TRIG_LEN=4, GAP_N=3, NUM_HOPS=2, SYNC_AMP=1000)
//  Reset: reset_n low mid-HTX -> all outputs 0 same cycle; start ignored until reset_n high.
//  start, scan_en=0: GPIO 0x004 for 4 cycles; I=1000 x16; I=-1000 x48; tx_valid x33.
//    Then 3 gap cycles, hop_idx=1, repeat; done pulses once after second gap.
//  scan_en=1 at start: 0x044 during TRIG, 0x040 during LOC; HSYNC lasts 16 cycles.
//  Passthrough: ramp itx_in=n -> itx_out=n delayed 1 cycle throughout HTX; 0 outside HTX.
//  abort at LOC cycle 5 with start same cycle: IDLE next cycle, IQ=0, GPIO=0, no done.
//  ACK_EN, bit0 never high: ack_err=1 after ACK_TIMEOUT cycles, IDLE.
//  ACK_EN, bit0 high 10 cycles after TRIG: LOC starts 2 sync cycles later.

Source files
------------

// File: rtl/tag_tx_ctrl_anc.sv
// Anchor-side hop transmit sequencer: GPIO trigger, +AMP loc-sync, -AMP hop-sync, IQ pass-through, gap.
// Define TAG_TX_ACK_CHECK_EN to wait for the peer's sync_ready (fp_gpio_in[0]) after each trigger.
module tag_tx_ctrl_anc #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned GPIO_REG_WIDTH = 12,
  parameter int unsigned SYNC_SIG_N     = 8192,
  parameter int unsigned SYNC_AMP       = 32000,
  parameter int unsigned TRIG_LEN       = 40,
  parameter int unsigned GAP_N          = 1024,
  parameter int unsigned NUM_HOPS       = 64,
  parameter int unsigned ACK_TIMEOUT    = 4096
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              start,
  input  logic                                              abort,
  input  logic                                              scan_en,
  input  logic [DATA_WIDTH-1:0]                             itx_in,
  input  logic [DATA_WIDTH-1:0]                             qtx_in,
  input  logic [GPIO_REG_WIDTH-1:0]                         fp_gpio_in,
  output logic [GPIO_REG_WIDTH-1:0]                         fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0]                         fp_gpio_ddr,
  output logic [DATA_WIDTH-1:0]                             itx_out,
  output logic [DATA_WIDTH-1:0]                             qtx_out,
  output logic                                              tx_valid,
  output logic [2:0]                                        tx_state,
  output logic [((NUM_HOPS > 1) ? $clog2(NUM_HOPS) : 1)-1:0] hop_idx,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              ack_err
);

  localparam int unsigned HW = (NUM_HOPS > 1) ? $clog2(NUM_HOPS) : 1;
  localparam logic [DATA_WIDTH-1:0]     AMP_P    = DATA_WIDTH'(SYNC_AMP);
  localparam logic [DATA_WIDTH-1:0]     AMP_N    = ~AMP_P + 1'b1;
  localparam logic [GPIO_REG_WIDTH-1:0] GPIO_DDR = GPIO_REG_WIDTH'(12'h044);
  localparam logic [GPIO_REG_WIDTH-1:0] SYNC_BIT = GPIO_REG_WIDTH'(12'h004);
  localparam logic [GPIO_REG_WIDTH-1:0] SCAN_BIT = GPIO_REG_WIDTH'(12'h040);
  localparam logic [HW-1:0]             LAST_HOP = HW'(NUM_HOPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_LOC   = 3'd2,
    S_HSYNC = 3'd3,
    S_HTX   = 3'd4,
    S_GAP   = 3'd5,
    S_ACKW  = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [HW-1:0]             hop_q, hop_d;
  logic                      scan_q, scan_d;
  logic                      done_q, done_d;
  logic                      ack_err_q, ack_err_d;
  logic [GPIO_REG_WIDTH-1:0] gpio_q, gpio_d;
  logic [DATA_WIDTH-1:0]     i_q, i_d, q_q, q_d;
  logic                      valid_q, valid_d;

  // Counter value loaded on entry so that a state of length L exits after L cycles.
  function automatic logic [15:0] reload(state_t s, logic scan);
    int unsigned len;
    case (s)
      S_TRIG:  len = TRIG_LEN;
      S_LOC:   len = SYNC_SIG_N;
      S_HSYNC: len = scan ? SYNC_SIG_N : 3 * SYNC_SIG_N;
      S_HTX:   len = 2 * SYNC_SIG_N + 1;
      S_GAP:   len = GAP_N;
      S_ACKW:  len = ACK_TIMEOUT;
      default: len = 1;
    endcase
    return 16'(len - 1);
  endfunction

`ifdef TAG_TX_ACK_CHECK_EN
  logic [1:0] ack_sync_q, ack_sync_d;
  logic       ack_seen;
  logic       unused_gpio;
  assign ack_sync_d  = {ack_sync_q[0], fp_gpio_in[0]};
  assign ack_seen    = ack_sync_q[1];
  assign unused_gpio = ^fp_gpio_in[GPIO_REG_WIDTH-1:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync_q <= '0;
    else          ack_sync_q <= ack_sync_d;
  end
`else
  logic unused_gpio;
  assign unused_gpio = ^fp_gpio_in;
`endif

  always_comb begin
    state_d   = state_q;
    hop_d     = hop_q;
    scan_d    = scan_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d   = S_TRIG;
          hop_d     = '0;
          scan_d    = scan_en;
          ack_err_d = 1'b0;
        end
`ifdef TAG_TX_ACK_CHECK_EN
        S_TRIG: if (cnt_q == '0) state_d = S_ACKW;
        S_ACKW: begin
          if (ack_seen) begin
            state_d = S_LOC;
          end else if (cnt_q == '0) begin
            state_d   = S_IDLE;
            ack_err_d = 1'b1;
          end
        end
`else
        S_TRIG: if (cnt_q == '0) state_d = S_LOC;
`endif
        S_LOC:   if (cnt_q == '0) state_d = S_HSYNC;
        S_HSYNC: if (cnt_q == '0) state_d = S_HTX;
        S_HTX:   if (cnt_q == '0) state_d = S_GAP;
        S_GAP: if (cnt_q == '0) begin
          if (hop_q == LAST_HOP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_TRIG;
            hop_d   = hop_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) cnt_d = reload(state_d, scan_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - 16'd1;
    else                    cnt_d = '0;

    // Outputs are registered from the next state so they line up with state_q.
    gpio_d  = '0;
    i_d     = '0;
    q_d     = '0;
    valid_d = 1'b0;
    case (state_d)
      S_TRIG:  gpio_d = SYNC_BIT | (scan_d ? SCAN_BIT : '0);
      S_ACKW:  gpio_d = scan_d ? SCAN_BIT : '0;
      S_LOC: begin
        gpio_d = scan_d ? SCAN_BIT : '0;
        i_d    = AMP_P;
      end
      S_HSYNC: i_d = AMP_N;
      S_HTX: begin
        i_d     = itx_in;
        q_d     = qtx_in;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hop_q     <= '0;
      scan_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      gpio_q    <= '0;
      i_q       <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hop_q     <= hop_d;
      scan_q    <= scan_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      gpio_q    <= gpio_d;
      i_q       <= i_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
    end
  end

  assign fp_gpio_out = gpio_q;
  assign fp_gpio_ddr = GPIO_DDR;
  assign itx_out     = i_q;
  assign qtx_out     = q_q;
  assign tx_valid    = valid_q;
  assign tx_state    = state_q;
  assign hop_idx     = hop_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule
